// File: rtl/md_sequencer_pkg.sv
// rtl/md_sequencer_pkg.sv - shared op/state encodings and sizing defaults for the multiply/divide unit
package md_sequencer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic is_iter_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// rtl/md_sequencer_if.sv - EX-stage to multiply/divide unit bundle
interface md_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             Start;
    logic [2:0]       MDOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Stall;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output Start, MDOp, A, B, input Busy, Stall, HI, LO);
    modport slave  (input Start, MDOp, A, B, output Busy, Stall, HI, LO);
endinterface

// File: rtl/md_iter_core.sv
// rtl/md_iter_core.sv - one radix-2 step per cycle on unsigned magnitudes
// Multiply: LSB-first shift-add into {acc, shf}. Divide: restoring, remainder in acc, quotient in shf.
module md_iter_core
    import md_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] shf
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] m_q,   m_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ok;

    always_comb begin
        add_sum = {1'b0, acc_q} + (shf_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        rem_sh  = {acc_q, shf_q[WIDTH-1]};
        rem_ok  = (rem_sh >= {1'b0, m_q});
        // Only used when rem_ok, where the true difference is below m_q and fits WIDTH bits.
        rem_sub = rem_sh[WIDTH-1:0] - m_q;

        acc_d = acc_q;
        shf_d = shf_q;
        m_d   = m_q;
        if (load) begin
            acc_d = '0;
            shf_d = a_mag;
            m_d   = b_mag;
        end else if (step) begin
            if (is_div) begin
                acc_d = rem_ok ? rem_sub : rem_sh[WIDTH-1:0];
                shf_d = {shf_q[WIDTH-2:0], rem_ok};
            end else begin
                acc_d = add_sum[WIDTH:1];
                shf_d = {add_sum[0], shf_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            shf_q <= '0;
            m_q   <= '0;
        end else begin
            acc_q <= acc_d;
            shf_q <= shf_d;
            m_q   <= m_d;
        end
    end

    assign acc = acc_q;
    assign shf = shf_q;

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - iterative HI/LO multiply/divide unit with hazard stall
// Owns the FSM, iteration counter, sign fix-up and the architectural HI/LO registers.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    md_sequencer_if.slave bus
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    md_op_e           op_q,    op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;

    md_op_e             start_op;
    logic               signed_start;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               load;
    logic               is_div_q;
    logic [WIDTH-1:0]   core_acc, core_shf;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        start_op     = md_op_e'(bus.MDOp);
        signed_start = is_signed_op(start_op);
        a_neg        = signed_start & bus.A[WIDTH-1];
        b_neg        = signed_start & bus.B[WIDTH-1];
        a_mag        = a_neg ? -bus.A : bus.A;
        b_mag        = b_neg ? -bus.B : bus.B;
        is_div_q     = (op_q == MD_DIV) || (op_q == MD_DIVU);

        // Quotient is negative when signs differ; remainder follows the dividend.
        prod_raw = {core_acc, core_shf};
        prod_fix = (sign_a_q ^ sign_b_q) ? -prod_raw : prod_raw;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -core_shf : core_shf;
        rem_fix  = sign_a_q ? -core_acc : core_acc;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    if (is_iter_op(start_op)) begin
                        load     = 1'b1;
                        op_d     = start_op;
                        sign_a_d = a_neg;
                        sign_b_d = b_neg;
                        bzero_d  = (bus.B == '0);
                        cnt_d    = '0;
                        state_d  = ST_CALC;
                    end else if (start_op == MD_MTHI) begin
                        hi_d = bus.A;
                    end else if (start_op == MD_MTLO) begin
                        lo_d = bus.A;
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (!bzero_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_NONE;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (state_q == ST_CALC),
        .is_div (is_div_q),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (core_acc),
        .shf    (core_shf)
    );

    assign bus.Busy  = (state_q != ST_IDLE);
    assign bus.Stall = bus.Busy | (bus.Start & is_iter_op(start_op));
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - scoreboard bench for md_sequencer with an arithmetic reference model
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_sequencer_if #(.WIDTH(W)) bus ();

    md_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] ref_hi   = '0;
    logic [W-1:0] ref_lo   = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the instruction's definition.
    function automatic void apply_model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input string nm);
        logic [63:0] p;
        longint      n, d;
        exp_t        e;
        case (op)
            3'd1: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                {ref_hi, ref_lo} = p;
            end
            3'd2: begin
                p = {32'b0, a} * {32'b0, b};
                {ref_hi, ref_lo} = p;
            end
            3'd3: if (b != 0) begin
                n = longint'($signed(a));
                d = longint'($signed(b));
                p = 64'(n / d);
                ref_lo = p[31:0];
                p = 64'(n % d);
                ref_hi = p[31:0];
            end
            3'd4: if (b != 0) begin
                ref_lo = a / b;
                ref_hi = a % b;
            end
            3'd5: ref_hi = a;
            3'd6: ref_lo = a;
            default: ;
        endcase
        if (op >= 3'd1 && op <= 3'd6) begin
            e.hi = ref_hi;
            e.lo = ref_lo;
            e.name = nm;
            exp_q.push_back(e);
        end
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.Busy !== 1'b0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: actual busy after %0d cycles required idle", k);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string nm);
        wait_idle();
        bus.Start = 1'b1;
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
        apply_model(op, a, b, nm);
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.MDOp  = 3'($urandom_range(0, 7));
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic pulse_ignored(input logic [2:0] op);
        bus.Start = 1'b1;
        bus.MDOp  = op;
        bus.A     = $urandom;
        bus.B     = $urandom;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Monitor: each HI/LO update event (Busy fall, or an accepted move) pops one expectation.
    initial begin
        logic busy_prev;
        logic mv_prev;
        logic exp_stall;
        int   run;
        exp_t e;
        busy_prev = 1'b0;
        mv_prev   = 1'b0;
        run       = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_prev = 1'b0;
                mv_prev   = 1'b0;
                run       = 0;
            end else begin
                exp_stall = bus.Busy | (bus.Start && bus.MDOp >= 3'd1 && bus.MDOp <= 3'd4);
                chk("stall", 64'(bus.Stall), 64'(exp_stall));
                if (busy_prev && !bus.Busy) chk("busy_len", 64'(run), 64'(W + 1));
                if ((busy_prev && !bus.Busy) || mv_prev) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: actual HI %h LO %h required no event", bus.HI, bus.LO);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_hi"}, 64'(bus.HI), 64'(e.hi));
                        chk({e.name, "_lo"}, 64'(bus.LO), 64'(e.lo));
                    end
                end
                run       = bus.Busy ? run + 1 : 0;
                busy_prev = bus.Busy;
                mv_prev   = bus.Start && !bus.Busy && (bus.MDOp == 3'd5 || bus.MDOp == 3'd6);
            end
        end
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        int           k;
        reset     = 1'b1;
        bus.Start = 1'b0;
        bus.MDOp  = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_hi", 64'(bus.HI), 64'd0);
        chk("rst_lo", 64'(bus.LO), 64'd0);
        chk("rst_stall", 64'(bus.Stall), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(3'd1, 32'hFFFF_FFFD, 32'd5, "mult_neg");
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        issue(3'd4, 32'd100, 32'd7, "divu");
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
        issue(3'd5, 32'h1234_5678, 32'd0, "mthi");
        chk("mthi_busy", 64'(bus.Busy), 64'd0);
        issue(3'd3, 32'h0000_0123, 32'd0, "div_zero");
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

        issue(3'd3, 32'd1000, 32'hFFFF_FFFD, "div_ign");
        repeat (10) @(posedge clk);
        #1;
        pulse_ignored(3'd6);
        pulse_ignored(3'd1);

        issue(3'd1, 32'h0BAD_F00D, 32'h8765_4321, "mult_abort");
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.Busy), 64'd0);
        chk("abort_hi", 64'(bus.HI), 64'd0);
        chk("abort_lo", 64'(bus.LO), 64'd0);
        exp_q.delete();
        ref_hi = '0;
        ref_lo = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(3'd1, 32'hFFFF_FFFD, 32'd5, "mult_after_rst");

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            k  = $urandom_range(0, 7);
            b  = (k == 0) ? 32'd0 : (k < 3) ? 32'($urandom_range(1, 20)) : $urandom;
            if (k == 7 && $urandom_range(0, 1) == 1) b = -b;
            issue(op, a, b, "rnd");
            if (bus.Busy && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #1;
                pulse_ignored(3'($urandom_range(1, 6)));
            end
        end

        wait_idle();
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: actual %0d pending results required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
